// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
//   Round-robin scheduler for the four AD7991 channels behind the I2C
//   controller. For each enabled channel it writes the config byte, holds the
//   I2C controller in restart, drops stale samples, checks the channel-ID
//   field of the next result and captures its 12-bit value.
//
//   Optional build macro: ADC_SCAN_AVERAGE_EN
//     When defined, each channel visit averages 4 matching captures
//     (truncated mean) before writing the channel register.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   enable              scanning allowed; when low, the current channel completes
//   chan_mask[3:0]      channels included in the scan
//   cfg_byte[7:0]       config byte to the I2C controller write register
//   i2c_rst             I2C controller restart, active-high
//   data_in[15:0]       conversion word: [13:12] channel ID, [11:0] value
//   data_valid          one-cycle strobe qualifying data_in
//   channel0..3[11:0]   last captured value per channel
//   ch_valid[3:0]       channel captured at least once since reset
//   scan_done           one-cycle pulse when a pass wraps
//   busy                high outside IDLE
//   error               sticky timeout / channel-ID mismatch flag
module adc_scan_sequencer #(
    parameter logic [3:0] CFG_LOW        = 4'b0000,
    parameter int         RST_CYCLES     = 16,
    parameter int         DISCARD        = 1,
    parameter int         TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  chan_mask,
    output logic [7:0]  cfg_byte,
    output logic        i2c_rst,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic [11:0] channel0,
    output logic [11:0] channel1,
    output logic [11:0] channel2,
    output logic [11:0] channel3,
    output logic [3:0]  ch_valid,
    output logic        scan_done,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, SELECT, WAIT, STORE, NEXT} state_t;

    localparam int          TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RMAX      = 8'(RST_CYCLES - 1);
    localparam logic [1:0]  DISC_INIT = 2'(DISCARD);

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic              done_nxt;
    logic [7:0]        rcnt;
    logic [1:0]        disc;
    logic [TW-1:0]     tcnt;
    logic [13:0]       sample;
    logic [3:0][11:0]  chan;
    logic [2:0]        pk_cur, pk_adv;
    logic              take, tmo, id_ok;
    logic              unused_hi;

`ifdef ADC_SCAN_AVERAGE_EN
    logic [13:0]       acc;
    logic [1:0]        acnt;
    logic [13:0]       acc_sum;
    assign acc_sum = acc + 14'(sample[11:0]);
`endif

    // {found, index}: lowest set mask bit at or above start, wrapping 3->0.
    function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] m);
        logic [2:0] r;
        logic [1:0] idx;
        r = {1'b0, start};
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign pk_cur    = pick(ptr, chan_mask);
    assign pk_adv    = pick(ptr + 2'd1, chan_mask);
    assign take      = (state == WAIT) && data_valid && (disc == 2'd0);
    assign tmo       = (state == WAIT) && !take && (tcnt == TMAX);
    assign id_ok     = (sample[13:12] == ptr);
    assign unused_hi = ^data_in[15:14];

    assign channel0 = chan[0];
    assign channel1 = chan[1];
    assign channel2 = chan[2];
    assign channel3 = chan[3];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state, pointer advance and pass-complete detection
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (chan_mask != 4'd0)) begin
                    state_nxt = SELECT;
                    ptr_nxt   = pk_cur[1:0];
                end
            end
            SELECT: if (rcnt == RMAX) state_nxt = WAIT;
            WAIT: begin
                if (take)     state_nxt = STORE;
                else if (tmo) state_nxt = NEXT;
            end
            STORE: begin
`ifdef ADC_SCAN_AVERAGE_EN
                // Return to WAIT for the remaining captures of this visit.
                state_nxt = (id_ok && (acnt != 2'd3)) ? WAIT : NEXT;
`else
                state_nxt = NEXT;
`endif
            end
            NEXT: begin
                if (pk_adv[2]) begin
                    ptr_nxt  = pk_adv[1:0];
                    // Wrap (new index not above the old) or a single-channel scan.
                    done_nxt = (pk_adv[1:0] <= ptr) || ($countones(chan_mask) == 1);
                end
                state_nxt = (enable && (chan_mask != 4'd0)) ? SELECT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy    = (state != IDLE);
        i2c_rst = (state == IDLE) || (state == SELECT);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= 2'd0;
            cfg_byte  <= {4'b0001, CFG_LOW};
            rcnt      <= 8'd0;
            disc      <= 2'd0;
            tcnt      <= '0;
            sample    <= 14'd0;
            chan      <= '0;
            ch_valid  <= 4'd0;
            scan_done <= 1'b0;
            error     <= 1'b0;
`ifdef ADC_SCAN_AVERAGE_EN
            acc       <= 14'd0;
            acnt      <= 2'd0;
`endif
        end else begin
            ptr       <= ptr_nxt;
            scan_done <= done_nxt;
            rcnt      <= (state == SELECT && state_nxt == SELECT) ? rcnt + 8'd1 : 8'd0;
            // Config byte is registered on entry so it is stable for the whole restart.
            if (state != SELECT && state_nxt == SELECT)
                cfg_byte <= {4'b0001 << ptr_nxt, CFG_LOW};
            case (state)
                SELECT: begin
                    disc <= DISC_INIT;
                    tcnt <= '0;
`ifdef ADC_SCAN_AVERAGE_EN
                    acc  <= 14'd0;
                    acnt <= 2'd0;
`endif
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (data_valid) begin
                        if (disc != 2'd0) disc   <= disc - 2'd1;
                        else              sample <= data_in[13:0];
                    end
                    if (tmo) begin
                        error <= 1'b1;
`ifdef ADC_SCAN_AVERAGE_EN
                        acc   <= 14'd0;
                        acnt  <= 2'd0;
`endif
                    end
                end
                STORE: begin
`ifdef ADC_SCAN_AVERAGE_EN
                    if (id_ok) begin
                        tcnt <= '0;
                        if (acnt == 2'd3) begin
                            chan[ptr]     <= acc_sum[13:2];
                            ch_valid[ptr] <= 1'b1;
                            acc           <= 14'd0;
                            acnt          <= 2'd0;
                        end else begin
                            acc  <= acc_sum;
                            acnt <= acnt + 2'd1;
                        end
                    end else begin
                        error <= 1'b1;
                        acc   <= 14'd0;
                        acnt  <= 2'd0;
                    end
`else
                    if (id_ok) begin
                        chan[ptr]     <= sample[11:0];
                        ch_valid[ptr] <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer. An ADC model answers every
// 50 cycles after the I2C restart is released; the first answer of each
// visit is a stale word (0xBAD) that the sequencer must discard.
module tb_adc_scan_sequencer;

    logic        clk, rst, enable, i2c_rst, data_valid, scan_done, busy, error;
    logic [3:0]  chan_mask, ch_valid;
    logic [7:0]  cfg_byte;
    logic [15:0] data_in;
    logic [11:0] channel0, channel1, channel2, channel3;

    int checks = 0;
    int errors = 0;

    // ADC model controls
    int silent_ch = -1;
    int bad_ch    = -1;
    int bad_id    = 0;
    bit seq_mode  = 0;

    logic [7:0] cfg_q[$];

    adc_scan_sequencer #(
        .CFG_LOW(4'b0000), .RST_CYCLES(8), .DISCARD(1), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask),
        .cfg_byte(cfg_byte), .i2c_rst(i2c_rst), .data_in(data_in),
        .data_valid(data_valid), .channel0(channel0), .channel1(channel1),
        .channel2(channel2), .channel3(channel3), .ch_valid(ch_valid),
        .scan_done(scan_done), .busy(busy), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC model: drives on negedge so inputs are stable at the active edge.
    initial begin
        int cnt, gidx;
        bit first;
        logic [1:0]  ch, id;
        logic [11:0] val;
        cnt = 0; gidx = 0; first = 1;
        data_valid = 1'b0;
        data_in    = 16'd0;
        forever begin
            @(negedge clk);
            data_valid = 1'b0;
            if (!rst || i2c_rst) begin
                cnt = 0; first = 1; gidx = 0;
            end else begin
                cnt++;
                if (cnt >= 50) begin
                    cnt = 0;
                    case (cfg_byte[7:4])
                        4'b0010: ch = 2'd1;
                        4'b0100: ch = 2'd2;
                        4'b1000: ch = 2'd3;
                        default: ch = 2'd0;
                    endcase
                    if (int'(ch) != silent_ch) begin
                        id = (int'(ch) == bad_ch) ? 2'(bad_id) : ch;
                        if (first)         val = 12'hBAD;
                        else if (seq_mode) val = 12'(10 + gidx);
                        else               val = 12'h100 + 12'(ch);
                        if (!first) gidx++;
                        first = 0;
                        data_in    = {2'b00, id, val};
                        data_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Records the config byte each time the I2C restart is released.
    initial begin
        logic p;
        p = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && p && !i2c_rst) cfg_q.push_back(cfg_byte);
            p = i2c_rst;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg"},  cfg_byte, 8'h10);
        chk({tag, "_i2c"},  i2c_rst, 1'b1);
        chk({tag, "_chan"}, {channel3, channel2, channel1, channel0}, 48'd0);
        chk({tag, "_flags"}, {ch_valid, scan_done, busy, error}, 7'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0;
        chan_mask = 4'd0;
        silent_ch = -1; bad_ch = -1; bad_id = 0; seq_mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cfg_q.delete();
    endtask

    // Wait for n scan_done pulses; at each, the last released config must be last_cfg.
    task automatic wait_done(input int n, input logic [7:0] last_cfg);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (scan_done) begin
                seen++;
                if (cfg_q.size() > 0) chk("done_last_ch", cfg_q[cfg_q.size()-1], last_cfg);
                else                  chk("done_last_ch", 8'h00, last_cfg);
            end
        end
        if (seen < n) bound_fail("scan_done");
    endtask

    // Wait for the I2C restart to fall with the given config byte loaded.
    task automatic wait_fall(input logic [7:0] cfg, output bit ok);
        logic p;
        ok = 0;
        p = i2c_rst;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (p && !i2c_rst && cfg_byte == cfg) begin
                ok = 1;
                break;
            end
            p = i2c_rst;
        end
        if (!ok) bound_fail("i2c_rst_fall");
    endtask

    typedef struct {
        logic [3:0]  mask;
        int          bad;
        int          n_done;
        logic [7:0]  last_cfg;
        logic [31:0] seq;
        logic [47:0] chans;   // {ch3, ch2, ch1, ch0}
        logic [3:0]  vld;
        logic        err;
    } vec_t;

    vec_t vecs[3];

    initial begin
        bit ok;
        int n, k;

        vecs[0] = '{4'hF, -1, 1, 8'h80, 32'h10204080, {12'h103, 12'h102, 12'h101, 12'h100}, 4'hF, 1'b0};
        vecs[1] = '{4'h5, -1, 2, 8'h40, 32'h10401040, {12'h000, 12'h102, 12'h000, 12'h100}, 4'h5, 1'b0};
        vecs[2] = '{4'hF,  1, 1, 8'h80, 32'h10204080, {12'h103, 12'h102, 12'h000, 12'h100}, 4'hD, 1'b1};

        rst = 1'b0; enable = 1'b0; chan_mask = 4'd0;
        #12;
        chk_reset_vals("reset");
        do_reset();

        // Full-pass, partial-mask and ID-mismatch scans
        foreach (vecs[i]) begin
            do_reset();
            bad_ch = vecs[i].bad;
            bad_id = 2;
            chan_mask = vecs[i].mask;
            enable = 1'b1;
            wait_done(vecs[i].n_done, vecs[i].last_cfg);
            if (cfg_q.size() >= 4) chk("cfg_seq", {cfg_q[0], cfg_q[1], cfg_q[2], cfg_q[3]}, vecs[i].seq);
            else                   chk("cfg_seq_len", cfg_q.size(), 4);
            chk("chans", {channel3, channel2, channel1, channel0}, vecs[i].chans);
            chk("ch_valid", ch_valid, vecs[i].vld);
            chk("error", error, vecs[i].err);
        end

        // Timeout on a silent channel 3
        do_reset();
        silent_ch = 3;
        chan_mask = 4'hF;
        enable = 1'b1;
        wait_fall(8'h80, ok);
        n = 0;
        while (!error && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 1000);
        @(negedge clk);
        chk("timeout_wrap_done", scan_done, 1'b1);
        chk("timeout_wrap_cfg", cfg_byte, 8'h10);
        chk("timeout_ch3", channel3, 12'h000);
        chk("timeout_vld", ch_valid, 4'h7);

        // Enable dropped while waiting on channel 1
        do_reset();
        chan_mask = 4'hF;
        enable = 1'b1;
        wait_fall(8'h20, ok);
        enable = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) bound_fail("idle_after_disable");
        chk("dis_ch1", channel1, 12'h101);
        chk("dis_vld", ch_valid, 4'h3);
        chk("dis_i2c", i2c_rst, 1'b1);
        repeat (20) @(negedge clk);
        chk("dis_stay_idle", busy, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        chk("resume_cfg", cfg_byte, 8'h40);
        chk("resume_busy", busy, 1'b1);

        // Asynchronous reset while in STORE
        do_reset();
        chan_mask = 4'hF;
        enable = 1'b1;
        wait_fall(8'h20, ok);
        k = 0;
        for (int c = 0; c < 2000 && k < 2; c++) begin
            @(posedge clk);
            if (data_valid) k++;
        end
        if (k < 2) bound_fail("store_entry");
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        chk("async_rst_held_i2c", i2c_rst, 1'b1);

        // Sequential values 10,11,12,13 on channel 0
        do_reset();
        seq_mode = 1;
        chan_mask = 4'h1;
        enable = 1'b1;
        wait_done(1, 8'h10);
`ifdef ADC_SCAN_AVERAGE_EN
        chk("seq_ch0", channel0, 12'd11);
`else
        chk("seq_ch0", channel0, 12'd10);
`endif
        chk("seq_vld", ch_valid, 4'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Round-robin scheduler for the four channels of the Pmod AD2 (AD7991) ADC behind the I2C controller.
- Per channel: builds the config byte, restarts the I2C controller, and discards stale samples. It then checks the channel-ID field of each result and captures the 12-bit value into a per-channel register.
- Replaces ad-hoc channel rotation between the I2C controller and the bin-to-BCD stage. Outputs feed BCD conversion directly.

Parameters:
- CFG_LOW, 4'b0000, low nibble of the config byte (REF_SEL, FLTR, bit-trial delay, sample delay).
- RST_CYCLES, 16, cycles the I2C controller restart is held high on a channel switch (range 1..255).
- DISCARD, 1, valid samples dropped after each channel switch before capture (range 0..3).
- TIMEOUT_CYCLES, 2_000_000, cycles to wait for data_valid before abandoning a channel (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  scanning allowed. When low, the block finishes the current channel then idles.
- chan_mask  in  4  bit n = 1 includes channel n in the scan
- cfg_byte  out  8  config byte to the I2C controller write register
- i2c_rst  out  1  restart of the I2C controller, active-high
- data_in  in  16  raw conversion word: [13:12] channel ID, [11:0] value
- data_valid  in  1  one-cycle strobe, data_in valid
- channel0..channel3  out  12 each  last captured value per channel
- ch_valid  out  4  bit n set once channel n has been captured since reset
- scan_done  out  1  one-cycle pulse after the last enabled channel of a pass
- busy  out  1  high in every state except IDLE
- error  out  1  sticky: timeout or channel-ID mismatch. Cleared only by reset.

Behaviour:
- Reset values:
  - State IDLE, channel pointer 0.
  - cfg_byte = {4'b0001, CFG_LOW}.
  - i2c_rst = 1.
  - channel0..3 = 0, ch_valid = 0, scan_done = 0, busy = 0, error = 0.
- States: IDLE, SELECT, WAIT, STORE, NEXT.
- IDLE:
  - i2c_rst held 1.
  - When enable = 1 and chan_mask != 0, load the pointer with the lowest set mask bit at or above the current pointer (wrapping) and go to SELECT.
- SELECT:
  - cfg_byte = {onehot(ptr), CFG_LOW}, registered on entry.
  - i2c_rst = 1 for exactly RST_CYCLES cycles, then deassert and go to WAIT.
  - Load the discard counter with DISCARD and clear the timeout counter.
- WAIT:
  - i2c_rst = 0.
  - On data_valid with discard counter > 0: decrement the counter and stay.
  - On data_valid with discard counter = 0: go to STORE.
  - Timeout counter increments each cycle. Reaching TIMEOUT_CYCLES-1 without capture sets error and goes to NEXT with no register update.
- STORE (1 cycle):
  - If data_in[13:12] == ptr: channel<ptr> <= data_in[11:0] and ch_valid[ptr] <= 1.
  - Otherwise set error and leave the register unchanged.
  - Then go to NEXT.
- NEXT (1 cycle):
  - Advance the pointer to the next set bit of the current chan_mask, wrapping 3→0.
  - scan_done pulses when the advance wraps, or when only one channel is enabled.
  - If enable = 0 or chan_mask = 0, go to IDLE. Otherwise go to SELECT.
- Latency per channel: RST_CYCLES + wait time for (DISCARD+1) valid samples + 2 cycles.
- data_valid is ignored outside WAIT.
- chan_mask is sampled only in IDLE and NEXT. Changes mid-channel take effect at the next advance.
- A disabled channel keeps its last value and its ch_valid bit.
- An asynchronous reset mid-operation returns everything to the reset values immediately. The I2C controller is held in restart through reset.

Optional Feature:
- Macro: ADC_SCAN_AVERAGE_EN.
- Defined:
  - STORE accumulates 4 matching captures per channel visit into a 14-bit accumulator. WAIT is re-entered between captures without reselecting the channel.
  - channel<n> <= accumulator[13:2], the truncated mean, written once after the 4th capture.
  - A mismatch or timeout discards the partial accumulation and sets error.
- Not defined: single-sample capture as above. No accumulator is instantiated.

Test Plan:
1. Reset with enable=1, mask=4'b1111; model returns ID=n, value=0x100+n after 50 cycles. Required:
   - cfg_byte sequence 0x10, 0x20, 0x40, 0x80.
   - First sample per channel discarded.
   - channel0..3 = 0x100..0x103, ch_valid=4'hF.
   - scan_done after channel 3.
2. mask=4'b0101 → channels 0 and 2 alternate only. channel1 and channel3 stay 0. scan_done pulses after each channel-2 capture.
3. Model returns ID=2 while channel 1 is selected → error=1 and channel1 unchanged. The scan proceeds to channel 2 and error remains set.
4. Model silent on channel 3 with TIMEOUT_CYCLES=1000 → error rises 1000 cycles after i2c_rst falls, no update, and the pointer wraps to 0.
5. Drop enable during WAIT on channel 1 → channel 1 still captured, then IDLE with busy=0 and i2c_rst=1. Re-enable → resumes at channel 2.
6. Assert rst during STORE → all outputs return to reset values the same cycle. With ADC_SCAN_AVERAGE_EN, samples 10, 11, 12, 13 → channel value 11.
